// File: rtl/reg_rename_unit_if.sv
// Rename-stage bus: decode-side rename request, commit-side retirement
// and recovery flush, grouped so decode drives the master modport and the
// rename unit receives the slave modport.
interface reg_rename_unit_if #(
    parameter int NUM_LOG_REGS  = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int LOG_W         = $clog2(NUM_LOG_REGS),
    parameter int PHYS_W        = $clog2(NUM_PHYS_REGS)
);
    logic              rename_valid;
    logic              rename_ready;
    logic [LOG_W-1:0]  rs_log;
    logic [LOG_W-1:0]  rt_log;
    logic              uses_rw;
    logic [LOG_W-1:0]  rw_log;
    logic [PHYS_W-1:0] rs_phys;
    logic [PHYS_W-1:0] rt_phys;
    logic [PHYS_W-1:0] rw_phys;
    logic [PHYS_W-1:0] prev_phys;
    logic              commit_valid;
    logic [LOG_W-1:0]  commit_log;
    logic [PHYS_W-1:0] commit_phys;
    logic [PHYS_W-1:0] commit_prev_phys;
    logic              flush;
    logic [PHYS_W:0]   free_count;

    modport master (
        output rename_valid, rs_log, rt_log, uses_rw, rw_log,
               commit_valid, commit_log, commit_phys, commit_prev_phys, flush,
        input  rename_ready, rs_phys, rt_phys, rw_phys, prev_phys, free_count
    );

    modport slave (
        input  rename_valid, rs_log, rt_log, uses_rw, rw_log,
               commit_valid, commit_log, commit_phys, commit_prev_phys, flush,
        output rename_ready, rs_phys, rt_phys, rw_phys, prev_phys, free_count
    );
endinterface

// File: rtl/reg_rename_unit.sv
// Register rename stage: speculative and architectural map tables plus a
// circular free list of physical registers. One rename per cycle, in-order
// commit returns the superseded register, flush rolls speculation back to
// the architectural state.
module reg_rename_unit #(
    parameter int NUM_LOG_REGS  = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int LOG_W         = $clog2(NUM_LOG_REGS),
    parameter int PHYS_W        = $clog2(NUM_PHYS_REGS)
) (
    input logic               clk,
    input logic               rst_n,
    reg_rename_unit_if.slave  bus
);
    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_LOG_REGS;
    localparam int PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    logic [PHYS_W-1:0] r_specMap [NUM_LOG_REGS];
    logic [PHYS_W-1:0] r_archMap [NUM_LOG_REGS];
    logic [PHYS_W-1:0] r_fifo    [FL_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_archHead;
    logic [PTR_W-1:0]  r_tail;
    logic [PHYS_W:0]   r_freeCount;

    logic              w_ready;
    logic              w_fire;
    logic              w_alloc;
    logic [PTR_W-1:0]  w_archHeadNext;

    // Pointers wrap at FL_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake, allocation decision and zero-latency map lookups.
    always_comb begin
        w_ready        = (r_freeCount != '0) && !bus.flush;
        w_fire         = bus.rename_valid && w_ready;
        w_alloc        = w_fire && bus.uses_rw && (bus.rw_log != '0);
        w_archHeadNext = bus.commit_valid ? ptrInc(r_archHead) : r_archHead;

        bus.rename_ready = w_ready;
        bus.free_count   = r_freeCount;
        bus.rs_phys      = r_specMap[bus.rs_log];
        bus.rt_phys      = r_specMap[bus.rt_log];
        bus.prev_phys    = r_specMap[bus.rw_log];
        bus.rw_phys      = w_alloc ? r_fifo[r_head] : '0;
    end

    // Architectural map and free-list tail follow in-order commits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LOG_REGS; i++) r_archMap[i] <= PHYS_W'(i);
            for (int k = 0; k < FL_DEPTH; k++) r_fifo[k] <= PHYS_W'(NUM_LOG_REGS + k);
            r_tail     <= '0;
            r_archHead <= '0;
        end else if (bus.commit_valid) begin
            if (bus.commit_log != '0) r_archMap[bus.commit_log] <= bus.commit_phys;
            r_fifo[r_tail] <= bus.commit_prev_phys;
            r_tail         <= ptrInc(r_tail);
            r_archHead     <= ptrInc(r_archHead);
        end
    end

    // Speculative map, allocation head and free count; flush restores them
    // from the architectural state including a same-cycle commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LOG_REGS; i++) r_specMap[i] <= PHYS_W'(i);
            r_head      <= '0;
            r_freeCount <= (PHYS_W+1)'(FL_DEPTH);
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_LOG_REGS; i++) begin
                if (bus.commit_valid && (bus.commit_log == LOG_W'(i)) && (i != 0))
                    r_specMap[i] <= bus.commit_phys;
                else
                    r_specMap[i] <= r_archMap[i];
            end
            r_head      <= w_archHeadNext;
            r_freeCount <= (PHYS_W+1)'(FL_DEPTH);
        end else begin
            if (w_alloc) begin
                r_specMap[bus.rw_log] <= r_fifo[r_head];
                r_head                <= ptrInc(r_head);
            end
            r_freeCount <= r_freeCount + (PHYS_W+1)'(bus.commit_valid)
                                       - (PHYS_W+1)'(w_alloc);
        end
    end

    // Commits must retire the oldest allocation, never logical 0, and never
    // overfill the free list.
    a_commitOrder : assert property (@(posedge clk) disable iff (!rst_n)
        bus.commit_valid |-> (bus.commit_phys == r_fifo[r_archHead]));
    a_commitLog : assert property (@(posedge clk) disable iff (!rst_n)
        bus.commit_valid |-> (bus.commit_log != '0));
    a_commitRoom : assert property (@(posedge clk) disable iff (!rst_n)
        bus.commit_valid |-> (r_freeCount < (PHYS_W+1)'(FL_DEPTH)));
endmodule

// File: tb/tb_reg_rename_unit.sv
// Directed bench for reg_rename_unit: expected lookup/allocation results are
// queued when a cycle's stimulus is driven and compared once outputs settle.
module tb_reg_rename_unit;
    localparam int NLOG  = 32;
    localparam int NPHYS = 64;

    typedef struct {
        string      tag;
        logic [5:0] rs;
        logic [5:0] rt;
        logic [5:0] rw;
        logic [5:0] prev;
        logic       rdy;
        logic [6:0] fc;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    int      checks = 0;
    int      failures = 0;
    expect_t sbQueue[$];

    reg_rename_unit_if #(.NUM_LOG_REGS(NLOG), .NUM_PHYS_REGS(NPHYS)) bus();

    reg_rename_unit #(.NUM_LOG_REGS(NLOG), .NUM_PHYS_REGS(NPHYS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses, input logic [4:0] rw);
        bus.rename_valid = v;
        bus.rs_log       = rs;
        bus.rt_log       = rt;
        bus.uses_rw      = uses;
        bus.rw_log       = rw;
    endtask

    task automatic applyCommit(input logic v, input logic [4:0] log_, input logic [5:0] phys,
                               input logic [5:0] prev);
        bus.commit_valid     = v;
        bus.commit_log       = log_;
        bus.commit_phys      = phys;
        bus.commit_prev_phys = prev;
    endtask

    task automatic expectOut(input string tag, input logic [5:0] rs, input logic [5:0] rt,
                             input logic [5:0] rw, input logic [5:0] prev,
                             input logic rdy, input logic [6:0] fc);
        expect_t e;
        e.tag = tag; e.rs = rs; e.rt = rt; e.rw = rw; e.prev = prev; e.rdy = rdy; e.fc = fc;
        sbQueue.push_back(e);
    endtask

    task automatic checkField(input string tag, input string field,
                              input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        #2;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkField(e.tag, "rs_phys",      32'(bus.rs_phys),      32'(e.rs));
            checkField(e.tag, "rt_phys",      32'(bus.rt_phys),      32'(e.rt));
            checkField(e.tag, "rw_phys",      32'(bus.rw_phys),      32'(e.rw));
            checkField(e.tag, "prev_phys",    32'(bus.prev_phys),    32'(e.prev));
            checkField(e.tag, "rename_ready", 32'(bus.rename_ready), 32'(e.rdy));
            checkField(e.tag, "free_count",   32'(bus.free_count),   32'(e.fc));
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyCommit(0, 0, 0, 0);
        bus.flush = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyCommit(0, 0, 0, 0);
        doReset();

        // Reset state and first rename.
        applyStimulus(1, 5, 0, 1, 3);
        expectOut("first", 5, 0, 32, 3, 1, 32);
        checkOutput();
        step();
        applyStimulus(0, 3, 0, 0, 0);
        expectOut("firstAfter", 32, 0, 0, 0, 1, 31);
        checkOutput();
        step();

        // Drain the free list with back-to-back renames of r1.
        doReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, 0, 0, 1, 1);
            expectOut($sformatf("drain%0d", i), 0, 0, 6'(32 + i),
                      (i == 0) ? 6'd1 : 6'(31 + i), 1, 7'(32 - i));
            checkOutput();
            step();
        end
        applyStimulus(1, 0, 0, 1, 1);
        expectOut("stall", 0, 0, 0, 63, 0, 0);
        checkOutput();
        step();
        applyStimulus(0, 1, 0, 0, 0);
        expectOut("stallMap", 63, 0, 0, 0, 0, 0);
        checkOutput();
        step();

        // Commit while empty: no bypass, then allocation after wrap.
        applyStimulus(1, 0, 0, 1, 1);
        applyCommit(1, 1, 32, 1);
        expectOut("commitFull", 0, 0, 0, 63, 0, 0);
        checkOutput();
        step();
        applyCommit(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 5);
        expectOut("wrapAlloc", 0, 0, 1, 5, 1, 1);
        checkOutput();
        step();
        applyStimulus(0, 0, 0, 0, 0);
        expectOut("wrapAfter", 0, 0, 0, 0, 0, 0);
        checkOutput();
        step();

        // Flush after a partial commit.
        doReset();
        applyStimulus(1, 0, 0, 1, 2);
        expectOut("flushR2", 0, 0, 32, 2, 1, 32);
        checkOutput();
        step();
        applyStimulus(1, 0, 0, 1, 4);
        expectOut("flushR4", 0, 0, 33, 4, 1, 31);
        checkOutput();
        step();
        applyStimulus(0, 2, 4, 0, 0);
        applyCommit(1, 2, 32, 2);
        expectOut("flushCommit", 32, 33, 0, 0, 1, 30);
        checkOutput();
        step();
        applyCommit(0, 0, 0, 0);
        bus.flush = 1'b1;
        expectOut("flushCycle", 32, 33, 0, 0, 0, 31);
        checkOutput();
        step();
        bus.flush = 1'b0;
        applyStimulus(1, 2, 4, 1, 7);
        expectOut("flushAfter", 32, 4, 33, 7, 1, 32);
        checkOutput();
        step();

        // Non-allocating renames: rw_log=0 and uses_rw=0.
        applyStimulus(1, 0, 0, 1, 0);
        expectOut("rwZero", 0, 0, 0, 0, 1, 31);
        checkOutput();
        step();
        applyStimulus(1, 0, 0, 0, 5);
        expectOut("noWrite", 0, 0, 0, 5, 1, 31);
        checkOutput();
        step();
        applyStimulus(0, 7, 5, 0, 0);
        expectOut("noWriteAfter", 33, 5, 0, 0, 1, 31);
        checkOutput();
        step();

        // Flush, commit and rename together, then a mid-sequence reset.
        doReset();
        applyStimulus(1, 0, 0, 1, 2);
        expectOut("comboR2", 0, 0, 32, 2, 1, 32);
        checkOutput();
        step();
        applyStimulus(1, 0, 0, 1, 4);
        expectOut("comboR4", 0, 0, 33, 4, 1, 31);
        checkOutput();
        step();
        applyStimulus(1, 0, 0, 1, 6);
        applyCommit(1, 2, 32, 2);
        bus.flush = 1'b1;
        expectOut("comboCycle", 0, 0, 0, 6, 0, 30);
        checkOutput();
        step();
        applyCommit(0, 0, 0, 0);
        bus.flush = 1'b0;
        applyStimulus(1, 2, 4, 1, 7);
        expectOut("comboAfter", 32, 4, 33, 7, 1, 32);
        checkOutput();
        step();
        applyStimulus(1, 7, 0, 1, 8);
        expectOut("preReset", 33, 0, 34, 8, 1, 31);
        checkOutput();
        rst_n = 1'b0;
        step();
        applyStimulus(0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        applyStimulus(1, 7, 8, 1, 9);
        expectOut("postReset", 7, 8, 32, 9, 1, 32);
        checkOutput();
        step();
        applyStimulus(0, 9, 0, 0, 0);
        expectOut("postResetAfter", 32, 0, 0, 0, 1, 31);
        checkOutput();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_rename_unit.md
Name: reg_rename_unit

Overview:
- Parametrised register-rename stage between decode and the active list / issue logic.
- Holds a speculative map table, an architectural (retirement) map table and a circular free-list FIFO of physical registers.
- Renames one instruction per cycle with a valid/ready handshake, returns freed registers on in-order commit, and restores the speculative state on a single-cycle flush.

Parameters:
- NUM_LOG_REGS, 32, number of logical registers; logical 0 is hardwired and never renamed.
- NUM_PHYS_REGS, 64, number of physical registers; must be greater than NUM_LOG_REGS.
- LOG_W, $clog2(NUM_LOG_REGS), logical index width.
- PHYS_W, $clog2(NUM_PHYS_REGS), physical index width.
- FL_DEPTH, NUM_PHYS_REGS-NUM_LOG_REGS, free-list capacity (derived, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rename_valid  in  1  decode presents an instruction
- rename_ready  out  1  rename can accept this cycle
- rs_log, rt_log  in  LOG_W  source logical registers
- uses_rw  in  1  instruction writes a destination
- rw_log  in  LOG_W  destination logical register
- rs_phys, rt_phys  out  PHYS_W  source physical registers
- rw_phys  out  PHYS_W  newly allocated destination physical register
- prev_phys  out  PHYS_W  previous mapping of rw_log, sent to the active list
- commit_valid  in  1  oldest destination-writing instruction retires
- commit_log  in  LOG_W  its logical destination
- commit_phys  in  PHYS_W  its allocated physical register
- commit_prev_phys  in  PHYS_W  register to free
- flush  in  1  mispredict/exception recovery
- free_count  out  PHYS_W+1  number of free physical registers

Behaviour:
- Reset, synchronous on rst_n=0:
  - spec_map[i] = arch_map[i] = i.
  - Free FIFO slot k = NUM_LOG_REGS+k.
  - head, arch_head and tail = 0; free_count = FL_DEPTH; rename_ready = 1.
  - Reset mid-operation discards all in-flight state identically.
- Lookup is combinational, zero latency:
  - rs_phys = spec_map[rs_log] and rt_phys = spec_map[rt_log].
  - prev_phys = spec_map[rw_log].
  - rw_phys = fifo[head] when an allocation occurs, else 0.
- rename_ready = (free_count != 0) && !flush.
- fire = rename_valid && rename_ready.
- Allocation happens when fire && uses_rw && rw_log != 0:
  - At the clock edge, spec_map[rw_log] <= fifo[head]; head increments modulo FL_DEPTH.
  - rw_log = 0, or uses_rw = 0: rw_phys = 0, no pop, map unchanged, fire still consumes the instruction.
- Commit, on commit_valid, is always accepted:
  - arch_map[commit_log] <= commit_phys.
  - fifo[tail] <= commit_prev_phys; tail and arch_head increment modulo FL_DEPTH.
  - Commits arrive in allocation order, so commit_phys equals fifo[arch_head]. Asserted in simulation, together with commit_log != 0 and free_count < FL_DEPTH on commit.
- free_count next = free_count + commit(push) - alloc(pop). A simultaneous push and pop leaves it unchanged.
- A pushed register is not bypassed to a same-cycle rename. At free_count = 0 rename stalls even if a commit occurs that cycle.
- Flush, on the next edge:
  - spec_map <= arch_map, including any same-cycle commit update.
  - head <= arch_head after the same-cycle commit advance.
  - free_count <= FL_DEPTH.
  - No allocation that cycle, since rename_ready = 0.
  - Speculatively popped registers between arch_head and head become free again in original order.
- Priority: rst_n > flush > commit/rename. Commit is still applied in a flush cycle.
- All pointer wrap-around is modulo FL_DEPTH. FL_DEPTH need not be a power of two.

Test Plan:
- Reset, then rs_log=5, rt_log=0, uses_rw=1, rw_log=3 -> rs_phys=5, rt_phys=0, rw_phys=32, prev_phys=3. Next cycle free_count=31 and spec_map[3]=32.
- 32 back-to-back renames of rw_log=1 -> rw_phys 32..63, prev_phys 1,32,..,62. Then free_count=0, rename_ready=0, and a 33rd valid stalls with the map unchanged.
- From the full state, commit(log 1, phys 32, prev 1) together with rename_valid -> no allocation that cycle, free_count=1. Next rename gets rw_phys=1 after head wraps to slot 0.
- rename r2 -> 32, rename r4 -> 33, commit(2, 32, prev 2), then flush -> spec_map[2]=32, spec_map[4]=4, free_count=32. Next rename of r7 gets rw_phys=33, prev_phys=7.
- uses_rw=1 with rw_log=0, and separately uses_rw=0 -> rw_phys=0, free_count unchanged, fire asserted.
- Flush, commit and rename_valid in the same cycle; then rst_n=0 mid-sequence -> flush case matches the flush-only result plus the commit; after reset, identity maps and free_count=32.
